// File: rtl/lcd_sync_module.sv
// lcd_sync_module: horizontal/vertical timing generator for a parallel RGB LCD panel.
// It produces the panel sync and data-enable strobes, and the ready/column/row
// addresses that the pixel/character control stage uses to choose a colour.
// Optional build macro: LCD_DE_DELAY_EN adds one pix_en-qualified register stage on
// hsync_sig, vsync_sig and de_sig. This lines them up with a downstream stage that
// registers its ROM address.
module lcd_sync_module #(
    parameter int H_SYNC  = 128,
    parameter int H_BACK  = 88,
    parameter int H_DISP  = 800,
    parameter int H_FRONT = 40,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int V_DISP  = 480,
    parameter int V_FRONT = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    output logic        hsync_sig,
    output logic        vsync_sig,
    output logic        de_sig,
    output logic        ready_sig,
    output logic [10:0] column_addr_sig,
    output logic [10:0] row_addr_sig,
    output logic        frame_start
);

    // Frame geometry. Counter comparisons use 11-bit copies of the constants.
    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int H_ACT   = H_SYNC + H_BACK;
    localparam int V_ACT   = V_SYNC + V_BACK;

    localparam logic [10:0] H_SYNC_C = 11'(H_SYNC);
    localparam logic [10:0] H_ACT_C  = 11'(H_ACT);
    localparam logic [10:0] H_END_C  = 11'(H_ACT + H_DISP);
    localparam logic [10:0] H_LAST_C = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_SYNC_C = 11'(V_SYNC);
    localparam logic [10:0] V_ACT_C  = 11'(V_ACT);
    localparam logic [10:0] V_END_C  = 11'(V_ACT + V_DISP);
    localparam logic [10:0] V_LAST_C = 11'(V_TOTAL - 1);

    logic [10:0] h_cnt_reg;
    logic [10:0] v_cnt_reg;

    logic        h_wrap;
    logic        v_wrap;
    logic        h_active;
    logic        v_active;

    logic        hsync_next;
    logic        vsync_next;
    logic        ready_next;
    logic        frame_start_next;
    logic [10:0] column_next;
    logic [10:0] row_next;

    logic        hsync_reg;
    logic        vsync_reg;
    logic        ready_reg;
    logic        frame_start_reg;
    logic [10:0] column_reg;
    logic [10:0] row_reg;

    assign h_wrap   = (h_cnt_reg == H_LAST_C);
    assign v_wrap   = (v_cnt_reg == V_LAST_C);
    assign h_active = (h_cnt_reg >= H_ACT_C) && (h_cnt_reg < H_END_C);
    assign v_active = (v_cnt_reg >= V_ACT_C) && (v_cnt_reg < V_END_C);

    // Decode the strobes from the current (pre-advance) counter position.
    // The address subtraction happens only inside the active window, so it cannot underflow.
    always_comb begin
        hsync_next       = !(h_cnt_reg < H_SYNC_C);
        vsync_next       = !(v_cnt_reg < V_SYNC_C);
        ready_next       = h_active && v_active;
        frame_start_next = (h_cnt_reg == 11'd0) && (v_cnt_reg == 11'd0);
        column_next      = 11'd0;
        row_next         = 11'd0;
        if (ready_next) begin
            column_next = h_cnt_reg - H_ACT_C;
            row_next    = v_cnt_reg - V_ACT_C;
        end
    end

    // Free-running raster counters. The line counter steps only when the pixel counter wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_reg <= 11'd0;
            v_cnt_reg <= 11'd0;
        end else if (pix_en) begin
            if (h_wrap) begin
                h_cnt_reg <= 11'd0;
                v_cnt_reg <= v_wrap ? 11'd0 : v_cnt_reg + 11'd1;
            end else begin
                h_cnt_reg <= h_cnt_reg + 11'd1;
            end
        end
    end

    // Registered outputs. They hold while pix_en is low, so frame_start is one enabled cycle wide.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_reg       <= 1'b1;
            vsync_reg       <= 1'b1;
            ready_reg       <= 1'b0;
            frame_start_reg <= 1'b0;
            column_reg      <= 11'd0;
            row_reg         <= 11'd0;
        end else if (pix_en) begin
            hsync_reg       <= hsync_next;
            vsync_reg       <= vsync_next;
            ready_reg       <= ready_next;
            frame_start_reg <= frame_start_next;
            column_reg      <= column_next;
            row_reg         <= row_next;
        end
    end

    assign ready_sig       = ready_reg;
    assign column_addr_sig = column_reg;
    assign row_addr_sig    = row_reg;
    assign frame_start     = frame_start_reg;

`ifdef LCD_DE_DELAY_EN
    // Bit 0 is hsync, bit 1 is vsync, bit 2 is de. The syncs idle high and de idles low.
    localparam logic [2:0] DLY_RST = 3'b011;

    logic [2:0] dly_in;
    logic [2:0] dly_out;

    assign dly_in = {ready_reg, vsync_reg, hsync_reg};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dly
            logic stage_reg;

            // One extra enabled-edge stage per panel strobe.
            always_ff @(posedge clk) begin
                if (rst) begin
                    stage_reg <= DLY_RST[gi];
                end else if (pix_en) begin
                    stage_reg <= dly_in[gi];
                end
            end

            assign dly_out[gi] = stage_reg;
        end
    endgenerate

    assign hsync_sig = dly_out[0];
    assign vsync_sig = dly_out[1];
    assign de_sig    = dly_out[2];
`else
    assign hsync_sig = hsync_reg;
    assign vsync_sig = vsync_reg;
    assign de_sig    = ready_reg;
`endif

endmodule

// File: tb/tb_lcd_sync_module.sv
// tb_lcd_sync_module: directed bench for lcd_sync_module.
// It uses a shrunken raster (12 x 8) so that several whole frames fit in a short run.
// Hand-computed checkpoints are backed by a per-edge reference of the timing equations.
// The LCD_DE_DELAY_EN build moves hsync/vsync/de expectations one enabled edge later.
module tb_lcd_sync_module;

    localparam int H_SYNC  = 3;
    localparam int H_BACK  = 2;
    localparam int H_DISP  = 5;
    localparam int H_FRONT = 2;
    localparam int V_SYNC  = 2;
    localparam int V_BACK  = 2;
    localparam int V_DISP  = 3;
    localparam int V_FRONT = 1;
    localparam int H_TOTAL = 12;
    localparam int V_TOTAL = 8;
    localparam int H_ACT   = 5;
    localparam int V_ACT   = 4;
`ifdef LCD_DE_DELAY_EN
    localparam int DLY = 1;
`else
    localparam int DLY = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_en = 1'b0;
    logic        hsync_sig;
    logic        vsync_sig;
    logic        de_sig;
    logic        ready_sig;
    logic [10:0] column_addr_sig;
    logic [10:0] row_addr_sig;
    logic        frame_start;

    int vectors = 0;
    int miscompares = 0;

    // Reference state: the next raster position, stage-1 outputs and the delayed strobes.
    int          mh;
    int          mv;
    logic        s_hs, s_vs, s_rdy, s_fs;
    logic [10:0] s_col, s_row;
    logic        d_hs, d_vs, d_de;

    int hs_low, vs_low, rdy_hi, de_hi;

    always #5 clk = ~clk;

    lcd_sync_module #(
        .H_SYNC (H_SYNC),
        .H_BACK (H_BACK),
        .H_DISP (H_DISP),
        .H_FRONT(H_FRONT),
        .V_SYNC (V_SYNC),
        .V_BACK (V_BACK),
        .V_DISP (V_DISP),
        .V_FRONT(V_FRONT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pix_en         (pix_en),
        .hsync_sig      (hsync_sig),
        .vsync_sig      (vsync_sig),
        .de_sig         (de_sig),
        .ready_sig      (ready_sig),
        .column_addr_sig(column_addr_sig),
        .row_addr_sig   (row_addr_sig),
        .frame_start    (frame_start)
    );

    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mh = 0;
        mv = 0;
        s_hs = 1'b1; s_vs = 1'b1; s_rdy = 1'b0; s_fs = 1'b0;
        s_col = 11'd0; s_row = 11'd0;
        d_hs = 1'b1; d_vs = 1'b1; d_de = 1'b0;
    endtask

    task automatic model_edge();
        d_hs  = s_hs;
        d_vs  = s_vs;
        d_de  = s_rdy;
        s_hs  = !(mh < H_SYNC);
        s_vs  = !(mv < V_SYNC);
        s_rdy = (mh >= H_ACT) && (mh < H_ACT + H_DISP) && (mv >= V_ACT) && (mv < V_ACT + V_DISP);
        s_col = s_rdy ? 11'(mh - H_ACT) : 11'd0;
        s_row = s_rdy ? 11'(mv - V_ACT) : 11'd0;
        s_fs  = (mh == 0) && (mv == 0);
        if (mh == H_TOTAL - 1) begin
            mh = 0;
            mv = (mv == V_TOTAL - 1) ? 0 : mv + 1;
        end else begin
            mh = mh + 1;
        end
    endtask

    task automatic check_model(input string ph);
        logic e_hs, e_vs, e_de;
        e_hs = (DLY == 1) ? d_hs : s_hs;
        e_vs = (DLY == 1) ? d_vs : s_vs;
        e_de = (DLY == 1) ? d_de : s_rdy;
        chk({ph, "_hsync"},  11'(hsync_sig),   11'(e_hs));
        chk({ph, "_vsync"},  11'(vsync_sig),   11'(e_vs));
        chk({ph, "_de"},     11'(de_sig),      11'(e_de));
        chk({ph, "_ready"},  11'(ready_sig),   11'(s_rdy));
        chk({ph, "_column"}, column_addr_sig,  s_col);
        chk({ph, "_row"},    row_addr_sig,     s_row);
        chk({ph, "_fstart"}, 11'(frame_start), 11'(s_fs));
    endtask

    initial begin
        // Reset with pix_en low, then again with pix_en high to show that reset wins.
        model_reset();
        rst = 1'b1;
        pix_en = 1'b0;
        tick(); tick();
        check_model("reset");
        chk("reset_hsync", 11'(hsync_sig), 11'd1);
        chk("reset_vsync", 11'(vsync_sig), 11'd1);
        pix_en = 1'b1;
        tick(); tick();
        check_model("reset_prio");

        // Constant enable for two frames, with hand-computed checkpoints.
        rst = 1'b0;
        hs_low = 0; vs_low = 0; rdy_hi = 0; de_hi = 0;
        for (int e = 1; e <= 200; e++) begin
            tick();
            model_edge();
            check_model("run");
            if (e == 1) begin
                chk("e1_fstart", 11'(frame_start), 11'd1);
                chk("e1_ready", 11'(ready_sig), 11'd0);
            end
            if (e == 2)       chk("e2_fstart", 11'(frame_start), 11'd0);
            if (e == 1 + DLY) begin
                chk("e1_hsync", 11'(hsync_sig), 11'd0);
                chk("e1_vsync", 11'(vsync_sig), 11'd0);
            end
            if (e == 3 + DLY)  chk("hsync_last_low", 11'(hsync_sig), 11'd0);
            if (e == 4 + DLY)  chk("hsync_release", 11'(hsync_sig), 11'd1);
            if (e == 24 + DLY) chk("vsync_last_low", 11'(vsync_sig), 11'd0);
            if (e == 25 + DLY) chk("vsync_release", 11'(vsync_sig), 11'd1);
            if (e == 53)       chk("pre_active_ready", 11'(ready_sig), 11'd0);
            if (e == 54) begin
                chk("first_active_ready", 11'(ready_sig), 11'd1);
                chk("first_active_col", column_addr_sig, 11'd0);
                chk("first_active_row", row_addr_sig, 11'd0);
                chk("first_active_de", 11'(de_sig), (DLY == 1) ? 11'd0 : 11'd1);
            end
            if (e == 55)       chk("de_after_first", 11'(de_sig), 11'd1);
            if (e == 58)       chk("line_end_col", column_addr_sig, 11'd4);
            if (e == 59)       chk("line_end_ready", 11'(ready_sig), 11'd0);
            if (e == 82) begin
                chk("last_px_ready", 11'(ready_sig), 11'd1);
                chk("last_px_col", column_addr_sig, 11'd4);
                chk("last_px_row", row_addr_sig, 11'd2);
            end
            if (e == 83)       chk("after_last_ready", 11'(ready_sig), 11'd0);
            if (e == 96)       chk("e96_fstart", 11'(frame_start), 11'd0);
            if (e == 97)       chk("e97_fstart", 11'(frame_start), 11'd1);
            if (e >= 97 && e <= 192) begin
                if (!hsync_sig) hs_low++;
                if (!vsync_sig) vs_low++;
                if (ready_sig)  rdy_hi++;
                if (de_sig)     de_hi++;
            end
        end
        chk("frame_hsync_low_edges", 11'(hs_low), 11'd24);
        chk("frame_vsync_low_edges", 11'(vs_low), 11'd24);
        chk("frame_ready_edges", 11'(rdy_hi), 11'd15);
        chk("frame_de_edges", 11'(de_hi), 11'd15);

        // Pseudo-random enable: advance on enabled edges and hold on disabled edges.
        for (int i = 0; i < 300; i++) begin
            pix_en = 1'($urandom_range(0, 1));
            tick();
            if (pix_en) begin
                model_edge();
                check_model("rnd_en");
            end else begin
                check_model("rnd_hold");
            end
        end

        // Move into the active window, then reset in the middle of the frame.
        pix_en = 1'b1;
        for (int i = 0; i < 200 && !(mh == 7 && mv == 5); i++) begin
            tick();
            model_edge();
            check_model("seek");
        end
        chk("seek_reached", 11'(mh == 7 && mv == 5), 11'd1);
        tick();
        model_edge();
        chk("mid_ready", 11'(ready_sig), 11'd1);
        chk("mid_col", column_addr_sig, 11'd2);
        chk("mid_row", row_addr_sig, 11'd1);
        rst = 1'b1;
        tick();
        model_reset();
        check_model("mid_reset");
        chk("mid_reset_col", column_addr_sig, 11'd0);
        rst = 1'b0;
        tick();
        model_edge();
        check_model("restart");
        chk("restart_fstart", 11'(frame_start), 11'd1);
        tick();
        model_edge();
        check_model("restart2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
